// File: rtl/hazard_ctrl_multi.sv
// Pipeline hazard controller: load-use and branch-operand detection over NUM_SRC operands,
// multi-cycle stall/flush sequencing, and a saturating stall-cycle counter.
module hazard_ctrl_multi #(
  parameter int REG_W      = 5,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_STALL = 1,
  parameter int BR_STALL   = 1,
  parameter int FLUSH_CYC  = 1,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pc_src,
  input  logic                     jmp,
  input  logic                     branch,
  input  logic [NUM_SRC-1:0]       src_used,
  input  logic [NUM_SRC*REG_W-1:0] rg_src,
  input  logic [REG_W-1:0]         rg_dst_ex,
  input  logic                     reg_write_ex,
  input  logic                     mem_rd_ex,
  input  logic [REG_W-1:0]         rg_dst_mem,
  input  logic                     mem_rd_mem,
  output logic                     zero_ctrl,
  output logic                     pc_write,
  output logic                     ir_write,
  output logic                     flush,
  output logic                     busy,
  output logic [CNT_W-1:0]         stall_cycles
);

  localparam int MAX_A = (LOAD_STALL > BR_STALL) ? LOAD_STALL : BR_STALL;
  localparam int MAX_C = (MAX_A > FLUSH_CYC) ? MAX_A : FLUSH_CYC;
  localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C + 1) : 1;

  localparam logic [CW-1:0] LD_RELOAD = CW'(LOAD_STALL - 1);
  localparam logic [CW-1:0] BR_RELOAD = CW'(BR_STALL - 1);
  localparam logic [CW-1:0] FL_RELOAD = CW'(FLUSH_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {IDLE, STALL, FLUSH} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          match_ex, match_mem;
  logic          br_haz, ld_haz, redir;
  logic          do_stall, do_flush;

  // Register 0 is hardwired zero, so it never creates a dependency.
  always_comb begin
    match_ex  = 1'b0;
    match_mem = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_used[i] && rg_src[i*REG_W +: REG_W] == rg_dst_ex && rg_dst_ex != '0)
        match_ex = 1'b1;
      if (src_used[i] && rg_src[i*REG_W +: REG_W] == rg_dst_mem && rg_dst_mem != '0)
        match_mem = 1'b1;
    end
  end

  assign br_haz = branch & ((reg_write_ex & match_ex) | (mem_rd_mem & match_mem));
  assign ld_haz = mem_rd_ex & match_ex;
  assign redir  = pc_src | jmp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt holds the bubble/flush cycles still owed after the current one.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (br_haz) begin
          if (BR_STALL > 1) begin
            state_nxt = STALL;
            cnt_nxt   = BR_RELOAD;
          end
        end else if (redir) begin
          if (FLUSH_CYC > 1) begin
            state_nxt = FLUSH;
            cnt_nxt   = FL_RELOAD;
          end
        end else if (ld_haz) begin
          if (LOAD_STALL > 1) begin
            state_nxt = STALL;
            cnt_nxt   = LD_RELOAD;
          end
        end
      end
      STALL: begin
        if (redir) begin
          if (FLUSH_CYC > 1) begin
            state_nxt = FLUSH;
            cnt_nxt   = FL_RELOAD;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else if (cnt == CNT_ONE) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      FLUSH: begin
        if (redir) begin
          cnt_nxt = FL_RELOAD;
        end else if (cnt == CNT_ONE) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    do_stall = 1'b0;
    do_flush = 1'b0;
    unique case (state)
      IDLE: begin
        do_stall = br_haz | (~redir & ld_haz);
        do_flush = ~br_haz & redir;
      end
      STALL: begin
        do_flush = redir;
        do_stall = ~redir;
      end
      FLUSH:   do_flush = 1'b1;
      default: ;
    endcase
    if (!rst_n) begin
      do_stall = 1'b0;
      do_flush = 1'b0;
    end
    zero_ctrl = do_stall;
    pc_write  = ~do_stall;
    ir_write  = ~do_stall;
    flush     = do_flush;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (zero_ctrl && stall_cycles != '1)
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl_multi.sv
// Self-checking bench for hazard_ctrl_multi: directed scenarios plus randomized traffic,
// all compared against a cycle-level model built from "cycles still owed" bookkeeping.
module tb_hazard_ctrl_multi;

  localparam int REG_W      = 5;
  localparam int NUM_SRC    = 2;
  localparam int LOAD_STALL = 3;
  localparam int BR_STALL   = 2;
  localparam int FLUSH_CYC  = 2;
  localparam int CNT_W      = 5;
  localparam int SAT        = (1 << CNT_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     pc_src = 1'b0, jmp = 1'b0, branch = 1'b0;
  logic [NUM_SRC-1:0]       src_used = '0;
  logic [NUM_SRC*REG_W-1:0] rg_src = '0;
  logic [REG_W-1:0]         rg_dst_ex = '0, rg_dst_mem = '0;
  logic                     reg_write_ex = 1'b0, mem_rd_ex = 1'b0, mem_rd_mem = 1'b0;
  logic                     zero_ctrl, pc_write, ir_write, flush, busy;
  logic [CNT_W-1:0]         stall_cycles;

  int tests = 0;
  int fails = 0;

  // Reference state: mode 0 none, 1 stalling, 2 flushing; owed = further cycles of that action.
  int mode = 0;
  int owed = 0;
  int model_cnt = 0;

  hazard_ctrl_multi #(
    .REG_W(REG_W), .NUM_SRC(NUM_SRC), .LOAD_STALL(LOAD_STALL),
    .BR_STALL(BR_STALL), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .jmp(jmp), .branch(branch),
    .src_used(src_used), .rg_src(rg_src), .rg_dst_ex(rg_dst_ex),
    .reg_write_ex(reg_write_ex), .mem_rd_ex(mem_rd_ex), .rg_dst_mem(rg_dst_mem),
    .mem_rd_mem(mem_rd_mem), .zero_ctrl(zero_ctrl), .pc_write(pc_write),
    .ir_write(ir_write), .flush(flush), .busy(busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit modelMatch(input logic [NUM_SRC-1:0] used,
                                    input logic [NUM_SRC*REG_W-1:0] srcs,
                                    input logic [REG_W-1:0] d);
    bit m = 0;
    for (int i = 0; i < NUM_SRC; i++)
      if (used[i] && d != 0 && srcs[i*REG_W +: REG_W] == d) m = 1;
    return m;
  endfunction

  task automatic applyStimulus(input bit rst, input bit p, input bit j, input bit b,
                               input logic [NUM_SRC-1:0] used,
                               input logic [NUM_SRC*REG_W-1:0] srcs,
                               input logic [REG_W-1:0] dex, input bit rwex, input bit mrex,
                               input logic [REG_W-1:0] dmem, input bit mrmem);
    int act;
    bit exp_busy, bh, lh, rd;
    @(negedge clk);
    pc_src = p; jmp = j; branch = b; src_used = used; rg_src = srcs;
    rg_dst_ex = dex; reg_write_ex = rwex; mem_rd_ex = mrex;
    rg_dst_mem = dmem; mem_rd_mem = mrmem;
    rst_n = !rst;
    #1;
    bh = b && ((rwex && modelMatch(used, srcs, dex)) || (mrmem && modelMatch(used, srcs, dmem)));
    lh = mrex && modelMatch(used, srcs, dex);
    rd = p || j;
    act = 0;
    if (rst) begin
      mode = 0; owed = 0; model_cnt = 0;
      exp_busy = 0;
    end else begin
      exp_busy = (mode != 0);
      if (mode == 2) begin
        act = 2;
        owed = rd ? FLUSH_CYC - 1 : owed - 1;
      end else if (mode == 1) begin
        if (rd) begin act = 2; mode = 2; owed = FLUSH_CYC - 1; end
        else begin act = 1; owed = owed - 1; end
      end else if (bh) begin
        act = 1; mode = 1; owed = BR_STALL - 1;
      end else if (rd) begin
        act = 2; mode = 2; owed = FLUSH_CYC - 1;
      end else if (lh) begin
        act = 1; mode = 1; owed = LOAD_STALL - 1;
      end
      if (owed <= 0) begin mode = 0; owed = 0; end
    end
    checkOutput("zero_ctrl", 32'(zero_ctrl), 32'(act == 1));
    checkOutput("pc_write", 32'(pc_write), 32'(act != 1));
    checkOutput("ir_write", 32'(ir_write), 32'(act != 1));
    checkOutput("flush", 32'(flush), 32'(act == 2));
    checkOutput("busy", 32'(busy), 32'(exp_busy));
    checkOutput("stall_cycles", 32'(stall_cycles), 32'(model_cnt));
    if (act == 1 && model_cnt < SAT) model_cnt++;
  endtask

  task automatic idleCycle(input bit rst);
    applyStimulus(rst, 0, 0, 0, '0, '0, '0, 0, 0, '0, 0);
  endtask

  task automatic loadUse(input logic [REG_W-1:0] dex, input logic [NUM_SRC-1:0] used, input bit j);
    applyStimulus(0, 0, j, 0, used, {5'd5, 5'd3}, dex, 1, 1, '0, 0);
  endtask

  initial begin
    logic [NUM_SRC*REG_W-1:0] srcs;
    idleCycle(1);
    idleCycle(1);
    idleCycle(0);
    // Load-use on op0 held for several cycles: stall, then re-stall after re-evaluation.
    for (int k = 0; k < 5; k++) loadUse(5'd3, 2'b11, 0);
    idleCycle(0); idleCycle(0); idleCycle(0);
    // No hazard: x0 destination, or matching operand masked off.
    loadUse(5'd0, 2'b11, 0);
    loadUse(5'd5, 2'b01, 0);
    idleCycle(0);
    // Branch hazard and taken redirect in the same cycle: stall wins.
    applyStimulus(0, 1, 0, 1, 2'b11, {5'd7, 5'd2}, 5'd7, 1, 0, '0, 0);
    idleCycle(0); idleCycle(0);
    // Jump during stall cycle 2 aborts the stall into a flush.
    loadUse(5'd3, 2'b11, 0);
    loadUse(5'd3, 2'b01, 1);
    idleCycle(0); idleCycle(0); idleCycle(0);
    // Reset asserted mid-stall.
    loadUse(5'd3, 2'b11, 0);
    loadUse(5'd3, 2'b11, 0);
    applyStimulus(1, 0, 0, 0, 2'b11, {5'd5, 5'd3}, 5'd3, 1, 1, '0, 0);
    idleCycle(0);
    // Long persisting hazard drives the counter into saturation.
    for (int k = 0; k < SAT + 6; k++) loadUse(5'd3, 2'b11, 0);
    idleCycle(0); idleCycle(0); idleCycle(0);
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NUM_SRC; i++) srcs[i*REG_W +: REG_W] = REG_W'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                    NUM_SRC'($urandom_range(0, 3)), srcs,
                    REG_W'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 2) == 0, REG_W'($urandom_range(0, 3)),
                    $urandom_range(0, 2) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
